// File: rtl/uart_command_assembler.sv
// Frames UART bytes (SOF + FRAME_BYTES payload [+ XOR checksum when CHECKSUM_EN]) into command words queued in an FWFT FIFO.
// Latency: a word is at the FIFO head 2 clk edges after the final byte's rx_valid cycle.
// Backpressure: none upstream; a frame completing into a full FIFO is dropped and counted unless the head is popped that cycle.
module uart_command_assembler #(
    parameter logic [7:0] SOF_BYTE       = 8'hAA,
    parameter int         FRAME_BYTES    = 20,
    parameter int         TIMEOUT_CYCLES = 400000,
    parameter int         FIFO_DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_byte,
    input  logic                     rx_valid,
    output logic [FRAME_BYTES*8-1:0] command,
    output logic                     command_fifo_empty,
    input  logic                     command_fifo_rd_en,
    output logic                     command_fifo_full,
    output logic                     frame_error,
    output logic [7:0]               drop_count,
    output logic                     busy
);

    localparam int CMD_W = FRAME_BYTES * 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUSH    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]    timeout_q, timeout_d;
    logic [CMD_W-1:0]   shift_q, shift_d;
`ifdef CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif
    logic               frame_error_q, frame_error_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CMD_W-1:0]   mem_q [FIFO_DEPTH];
    logic [CMD_W-1:0]   mem_d [FIFO_DEPTH];
    logic [CMD_W-1:0]   command_q, command_d;

    logic push_req;
    logic drop_frame;
    logic fifo_empty;
    logic fifo_full;
    logic wr_en;
    logic rd_en;
    logic drop_inc;

    // Framing FSM: next state, byte collection and inter-byte timeout.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        timeout_d     = timeout_q;
        shift_d       = shift_q;
`ifdef CHECKSUM_EN
        chk_d         = chk_q;
`endif
        frame_error_d = 1'b0;
        push_req      = 1'b0;
        drop_frame    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == SOF_BYTE)) begin
                    state_d    = ST_COLLECT;
                    byte_cnt_d = '0;
                    timeout_d  = '0;
                    shift_d    = '0;
`ifdef CHECKSUM_EN
                    chk_d      = '0;
`endif
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    timeout_d = '0;
`ifdef CHECKSUM_EN
                    if (byte_cnt_q == CNT_W'(FRAME_BYTES)) begin
                        if (rx_byte == chk_q) begin
                            state_d = ST_PUSH;
                        end else begin
                            state_d       = ST_IDLE;
                            frame_error_d = 1'b1;
                            drop_frame    = 1'b1;
                        end
                    end else begin
                        shift_d    = {shift_q[CMD_W-9:0], rx_byte};
                        chk_d      = chk_q ^ rx_byte;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
`else
                    shift_d    = {shift_q[CMD_W-9:0], rx_byte};
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(FRAME_BYTES - 1)) begin
                        state_d = ST_PUSH;
                    end
`endif
                end else if (timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle brings the gap to TIMEOUT_CYCLES: abandon the frame.
                    state_d       = ST_IDLE;
                    timeout_d     = '0;
                    frame_error_d = 1'b1;
                    drop_frame    = 1'b1;
                end else begin
                    timeout_d = timeout_q + TO_W'(1);
                end
            end
            ST_PUSH: begin
                push_req = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FWFT FIFO; command_q tracks the post-update head so it holds its value once drained.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en      = command_fifo_rd_en && !fifo_empty;
        wr_en      = push_req && (!fifo_full || command_fifo_rd_en);
        drop_inc   = drop_frame || (push_req && !wr_en);

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        end
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};

        command_d = command_q;
        if (wr_ptr_d != rd_ptr_d) begin
            command_d = mem_d[rd_ptr_d[AW-1:0]];
        end

        drop_count_d = drop_count_q;
        if (drop_inc && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            byte_cnt_q    <= '0;
            timeout_q     <= '0;
            shift_q       <= '0;
`ifdef CHECKSUM_EN
            chk_q         <= '0;
`endif
            frame_error_q <= 1'b0;
            drop_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            command_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            timeout_q     <= timeout_d;
            shift_q       <= shift_d;
`ifdef CHECKSUM_EN
            chk_q         <= chk_d;
`endif
            frame_error_q <= frame_error_d;
            drop_count_q  <= drop_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            command_q     <= command_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign command            = command_q;
    assign command_fifo_empty = fifo_empty;
    assign command_fifo_full  = fifo_full;
    assign frame_error        = frame_error_q;
    assign drop_count         = drop_count_q;
    assign busy               = (state_q != ST_IDLE);

endmodule
